// File: rtl/m_xy_lane_checker.sv
// Per-lane x |=> y implication monitor with exact-latency or window modes,
// failure pulses, sticky flags, saturating counters and first-failure capture.
module m_xy_lane_checker #(
   parameter int WIDTH = 8,
   parameter int DELAY = 1,
   parameter int MODE  = 0,
   parameter int CNT_W = 16,
   localparam int LW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] err_pulse,
   output logic [WIDTH-1:0] err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] pass_count,
   output logic             first_err_valid,
   output logic [LW-1:0]    first_err_lane
);

   localparam int PW = $clog2(WIDTH * DELAY + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

   // pend[a] holds, per lane, obligations created a+1 edges ago
   logic [WIDTH-1:0] pend [DELAY];

   logic [WIDTH-1:0] fail;
   logic [PW-1:0]    fcnt;
   logic [PW-1:0]    pcnt;
   logic [LW-1:0]    low;
   logic [SW-1:0]    esum;
   logic [SW-1:0]    psum;
   logic [CNT_W-1:0] err_nxt;
   logic [CNT_W-1:0] pass_nxt;

   always_comb begin
      fail = pend[DELAY-1] & ~y;
      fcnt = '0;
      pcnt = '0;
      low  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         fcnt = fcnt + PW'(fail[i]);
         if (fail[i]) low = LW'(i);
      end
      // window mode discharges every pending age; exact mode only the oldest
      for (int a = 0; a < DELAY; a++) begin
         if (MODE == 1 || a == DELAY - 1) begin
            for (int i = 0; i < WIDTH; i++)
               pcnt = pcnt + PW'(pend[a][i] & y[i]);
         end
      end
      esum     = SW'(err_count) + SW'(fcnt);
      psum     = SW'(pass_count) + SW'(pcnt);
      err_nxt  = (esum > CMAX) ? CMAX[CNT_W-1:0] : esum[CNT_W-1:0];
      pass_nxt = (psum > CMAX) ? CMAX[CNT_W-1:0] : psum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int a = 0; a < DELAY; a++)
            pend[a] <= '0;
         err_pulse       <= '0;
         err_sticky      <= '0;
         err_count       <= '0;
         pass_count      <= '0;
         first_err_valid <= 1'b0;
         first_err_lane  <= '0;
      end else begin
         pend[0] <= en ? x : '0;
         for (int a = 1; a < DELAY; a++)
            pend[a] <= (MODE == 1) ? (pend[a-1] & ~y) : pend[a-1];
         err_pulse <= fail;
         if (clr) begin
            err_sticky      <= '0;
            err_count       <= '0;
            pass_count      <= '0;
            first_err_valid <= 1'b0;
            first_err_lane  <= '0;
         end else begin
            err_sticky <= err_sticky | fail;
            err_count  <= err_nxt;
            pass_count <= pass_nxt;
            if (!first_err_valid && (|fail)) begin
               first_err_valid <= 1'b1;
               first_err_lane  <= low;
            end
         end
      end
   end

endmodule

// File: tb/tb_m_xy_lane_checker.sv
// Randomized bench: three checker configurations against a timestamp-based
// obligation model.
module tb_m_xy_lane_checker;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [7:0] x;
   logic [7:0] y;

   logic [7:0]  pA, sA;
   logic [15:0] eA, qA;
   logic        fvA;
   logic [2:0]  lA;

   logic [7:0]  pB, sB;
   logic [1:0]  eB, qB;
   logic        fvB;
   logic [2:0]  lB;

   logic [4:0]  pC, sC;
   logic [7:0]  eC, qC;
   logic        fvC;
   logic [2:0]  lC;

   m_xy_lane_checker #(.WIDTH(8), .DELAY(3), .MODE(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .en(en), .clr(clr),
      .err_pulse(pA), .err_sticky(sA), .err_count(eA), .pass_count(qA),
      .first_err_valid(fvA), .first_err_lane(lA)
   );

   m_xy_lane_checker #(.WIDTH(8), .DELAY(1), .MODE(0), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .en(en), .clr(clr),
      .err_pulse(pB), .err_sticky(sB), .err_count(eB), .pass_count(qB),
      .first_err_valid(fvB), .first_err_lane(lB)
   );

   m_xy_lane_checker #(.WIDTH(5), .DELAY(4), .MODE(0), .CNT_W(8)) u_c (
      .clk(clk), .rst_n(rst_n), .x(x[4:0]), .y(y[4:0]), .en(en), .clr(clr),
      .err_pulse(pC), .err_sticky(sC), .err_count(eC), .pass_count(qC),
      .first_err_valid(fvC), .first_err_lane(lC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int wd [3] = '{8, 8, 5};
   int dl [3] = '{3, 1, 4};
   int md [3] = '{1, 0, 0};
   int cm [3] = '{65535, 3, 255};

   // ob[k][t] = lanes whose obligation created at edge t is still open
   logic [7:0] ob [3][4096];
   logic [7:0] e_pulse  [3];
   logic [7:0] e_sticky [3];
   int         e_err    [3];
   int         e_pass   [3];
   logic       e_fv     [3];
   int         e_fl     [3];

   int t;
   int n_chk;
   int n_pass;

   task automatic check(input string tag, input int k,
                        input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s dut%0d t=%0d got=%0h exp=%0h", tag, k, t, got, exp);
   endtask

   task automatic model_edge(input int k);
      logic [7:0] mask;
      logic [7:0] f;
      int np;
      int nf;
      int d;
      bit found;
      mask = 8'((1 << wd[k]) - 1);
      d = dl[k];
      if (!rst_n) begin
         for (int j = 0; j <= d; j++) ob[k][t-j] = '0;
         e_pulse[k] = '0; e_sticky[k] = '0;
         e_err[k] = 0; e_pass[k] = 0;
         e_fv[k] = 1'b0; e_fl[k] = 0;
         return;
      end
      f = '0;
      np = 0;
      for (int i = 0; i < wd[k]; i++) begin
         if (md[k] == 1 && y[i]) begin
            for (int j = 1; j <= d; j++) begin
               if (ob[k][t-j][i]) begin
                  np++;
                  ob[k][t-j][i] = 1'b0;
               end
            end
         end else if (ob[k][t-d][i]) begin
            if (y[i]) np++;
            else f[i] = 1'b1;
            ob[k][t-d][i] = 1'b0;
         end
      end
      ob[k][t] = en ? (x & mask) : '0;
      e_pulse[k] = f;
      if (clr) begin
         e_sticky[k] = '0; e_err[k] = 0; e_pass[k] = 0;
         e_fv[k] = 1'b0; e_fl[k] = 0;
      end else begin
         nf = $countones(f);
         e_sticky[k] = e_sticky[k] | f;
         e_err[k]  = (e_err[k] + nf > cm[k]) ? cm[k] : e_err[k] + nf;
         e_pass[k] = (e_pass[k] + np > cm[k]) ? cm[k] : e_pass[k] + np;
         if (!e_fv[k] && f != 0) begin
            e_fv[k] = 1'b1;
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
               if (f[i] && !found) begin
                  e_fl[k] = i;
                  found = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check_dut(input int k, input logic [31:0] p, input logic [31:0] s,
                            input logic [31:0] e, input logic [31:0] q,
                            input logic [31:0] fv, input logic [31:0] fl);
      check("err_pulse", k, p, 32'(e_pulse[k]));
      check("err_sticky", k, s, 32'(e_sticky[k]));
      check("err_count", k, e, 32'(e_err[k]));
      check("pass_count", k, q, 32'(e_pass[k]));
      check("first_valid", k, fv, 32'(e_fv[k]));
      check("first_lane", k, fl, 32'(e_fl[k]));
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4096; j++) ob[k][j] = '0;
         e_pulse[k] = '0; e_sticky[k] = '0;
         e_err[k] = 0; e_pass[k] = 0;
         e_fv[k] = 1'b0; e_fl[k] = 0;
      end
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; x = '0; y = '0;
      for (int c = 0; c < 3000; c++) begin
         t = c + 8;
         rst_n = !(c < 3 || $urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 39) == 0);
         x   = 8'($urandom) & 8'($urandom | $urandom);
         if (((c / 300) % 2) == 1) y = 8'($urandom | $urandom);
         else y = 8'($urandom & $urandom);
         @(posedge clk);
         for (int k = 0; k < 3; k++) model_edge(k);
         #1;
         check_dut(0, 32'(pA), 32'(sA), 32'(eA), 32'(qA), 32'(fvA), 32'(lA));
         check_dut(1, 32'(pB), 32'(sB), 32'(eB), 32'(qB), 32'(fvB), 32'(lB));
         check_dut(2, 32'(pC), 32'(sC), 32'(eC), 32'(qC), 32'(fvC), 32'(lC));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
